// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through one full-adder
// slice with the inter-slice carry held in a single flop; done pulses after WIDTH cycles.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,   // synchronous, active-low
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    // state | meaning
    // IDLE  | waiting for start; sum/cout hold last result
    // SHIFT | one bit slice per edge, WIDTH edges total
    // DONE  | result valid, done high for this single cycle
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             s_bit;
    logic [WIDTH-1:0] s_d;
    logic             c_d;

    always_comb begin
        s_bit = a_q[0] ^ b_q[0] ^ c_q;
        c_d   = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
        s_d   = {s_bit, s_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        c_q     <= cin_i;
                        s_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    s_q   <= s_d;
                    c_q   <= c_d;
                    cnt_q <= cnt_q + CW'(1);
                    // Output regs only move on the last slice so the previous result stays visible.
                    if (cnt_q == CNT_LAST) begin
                        sum_q   <= s_d;
                        cout_q  <= c_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table, multi-cycle corner
// sequences, exhaustive WIDTH=4 sweep and random WIDTH=8 vectors vs a+b+cin.
module tb_serial_adder;

    logic       clk_i;
    logic       reset_i;

    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    int total;
    int bad;

    logic [3:0] hold_sum4;
    logic       hold_cout4;

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .start_i(start4),
        .a_i    (a4),
        .b_i    (b4),
        .cin_i  (cin4),
        .busy_o (busy4),
        .done_o (done4),
        .sum_o  (sum4),
        .cout_o (cout4)
    );

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .start_i(start8),
        .a_i    (a8),
        .b_i    (b8),
        .cin_i  (cin8),
        .busy_o (busy8),
        .done_o (done8),
        .sum_o  (sum8),
        .cout_o (cout8)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Full WIDTH=4 transaction; expected result passed in, previous result must stay held.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c,
                        input logic [3:0] es, input logic ec, input string nm);
        int lat;
        bit seen;
        bit held_ok;
        bit busy_ok;
        start4 = 1'b1; a4 = a; b4 = b; cin4 = c;
        tick();
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
        chk({nm, " busy_after_accept"}, busy4, 1);
        lat = 0; seen = 0; held_ok = 1; busy_ok = 1;
        while (!seen && lat < 20) begin
            tick();
            lat++;
            if (!busy4) busy_ok = 0;
            if (done4) seen = 1;
            else if (sum4 !== hold_sum4 || cout4 !== hold_cout4) held_ok = 0;
        end
        chk({nm, " latency"}, lat, 4);
        chk({nm, " busy_during"}, busy_ok, 1);
        chk({nm, " prev_held"}, held_ok, 1);
        chk({nm, " sum"}, sum4, es);
        chk({nm, " cout"}, cout4, ec);
        hold_sum4 = es; hold_cout4 = ec;
        tick();
        chk({nm, " done_fall"}, done4, 0);
        chk({nm, " busy_fall"}, busy4, 0);
        chk({nm, " sum_hold_idle"}, {cout4, sum4}, {ec, es});
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] exp;
        int lat;
        bit seen;
        exp = 9'(a) + 9'(b) + 9'(c);
        start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
        tick();
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0; seen = 0;
        while (!seen && lat < 30) begin
            tick();
            lat++;
            if (done8) seen = 1;
        end
        chk("w8 latency", lat, 8);
        chk("w8 result", {cout8, sum8}, exp);
        tick();
        chk("w8 busy_fall", busy8, 0);
    endtask

    initial begin
        vec_t vecs[6];
        int   dones;
        int   q[$];
        bit   ok;
        logic [4:0] e5;

        total = 0; bad = 0;
        hold_sum4 = '0; hold_cout4 = 1'b0;
        start4 = 0; a4 = '0; b4 = '0; cin4 = 0;
        start8 = 0; a8 = '0; b8 = '0; cin8 = 0;

        vecs[0] = '{4'd3,  4'd5,  1'b0, 4'd8,  1'b0};
        vecs[1] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1};
        vecs[2] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
        vecs[3] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0};
        vecs[4] = '{4'd9,  4'd6,  1'b0, 4'd15, 1'b0};
        vecs[5] = '{4'd7,  4'd9,  1'b1, 4'd1,  1'b1};

        // Reset, with start asserted to confirm reset wins.
        reset_i = 1'b0;
        start4 = 1'b1; a4 = 4'd3; b4 = 4'd3;
        tick(); tick(); tick();
        chk("reset busy", busy4, 0);
        chk("reset done", done4, 0);
        chk("reset sum", sum4, 0);
        chk("reset cout", cout4, 0);
        chk("reset busy w8", busy8, 0);
        start4 = 1'b0;
        reset_i = 1'b1;
        tick();
        chk("idle no start", busy4, 0);

        for (int i = 0; i < 6; i++)
            run4(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout,
                 $sformatf("vec%0d", i));

        // Start while busy is ignored, not queued.
        start4 = 1'b1; a4 = 4'd2; b4 = 4'd2; cin4 = 1'b0;
        tick();
        start4 = 1'b0;
        dones = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 2) begin start4 = 1'b1; a4 = 4'd7; b4 = 4'd7; end
            if (i == 3) start4 = 1'b0;
            tick();
            if (done4) dones++;
        end
        chk("ignore dones", dones, 1);
        chk("ignore sum", {cout4, sum4}, 5'd4);
        chk("ignore busy", busy4, 0);
        hold_sum4 = 4'd4; hold_cout4 = 1'b0;

        // Reset on the second SHIFT edge abandons the operation.
        start4 = 1'b1; a4 = 4'd9; b4 = 4'd6;
        tick();
        start4 = 1'b0;
        tick();
        reset_i = 1'b0;
        tick();
        chk("midreset busy", busy4, 0);
        chk("midreset sum", sum4, 0);
        chk("midreset cout", cout4, 0);
        reset_i = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done4) dones++;
        end
        chk("midreset no done", dones, 0);
        hold_sum4 = '0; hold_cout4 = 1'b0;
        run4(4'd1, 4'd1, 1'b0, 4'd2, 1'b0, "after_reset");

        // Continuous start re-triggers every WIDTH+2 cycles.
        start4 = 1'b1; a4 = 4'd5; b4 = 4'd6; cin4 = 1'b1;
        ok = 1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done4) begin
                q.push_back(i);
                if (sum4 !== 4'd12 || cout4 !== 1'b0) ok = 0;
            end
        end
        start4 = 1'b0;
        chk("cont count", q.size(), 5);
        chk("cont result", ok, 1);
        ok = 1;
        foreach (q[k]) if (q[k] != 4 + 6 * k) ok = 0;
        chk("cont spacing", ok, 1);
        tick(); tick();
        hold_sum4 = 4'd12; hold_cout4 = 1'b0;

        // Exhaustive WIDTH=4 sweep against plain arithmetic.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    e5 = 5'(a + b + c);
                    run4(4'(a), 4'(b), 1'(c), e5[3:0], e5[4], "sweep");
                end

        // WIDTH=8: corners then random vectors.
        run8(8'hFF, 8'hFF, 1'b1);
        run8(8'hFF, 8'h01, 1'b0);
        run8(8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 200; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around a single carry flip-flop. It sits directly downstream of the team's `dff` storage cell: the carry between bit slices is held in one registered bit, and operand and sum bits are shifted LSB-first through one full-adder slice. It accepts two operands and a carry-in on a start pulse. It returns the registered sum and carry-out with a one-cycle done pulse, trading the ripple adder's area for WIDTH cycles of latency.

## Interface
- WIDTH, 4, operand/sum width in bits (legal range 2..16)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk, overrides all other inputs
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- cin  in  1  carry-in, captured into the carry flip-flop on accepted start
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse; sum/cout valid while high and held afterwards
- sum  out  WIDTH  registered result, (a+b+cin) mod 2^WIDTH
- cout  out  1  registered carry out of bit WIDTH-1

## Operation
- Internal state:
  - shift registers A, B (WIDTH bits each)
  - sum shift register S (WIDTH bits)
  - carry flip-flop C
  - bit counter cnt (ceil(log2 WIDTH) bits)
  - FSM {IDLE, SHIFT, DONE}
- IDLE: if start=1, load A<=a, B<=b, C<=cin, S<=0, cnt<=0, go SHIFT. Otherwise hold.
- SHIFT, every edge:
  - s = A[0]^B[0]^C; c' = A[0]&B[0] | A[0]&C | B[0]&C
  - A<=A>>1, B<=B>>1, S<={s, S[WIDTH-1:1]}, C<=c', cnt<=cnt+1
- SHIFT, on the edge where cnt==WIDTH-1:
  - also load output regs sum<={s, S[WIDTH-1:1]}, cout<=c'
  - go DONE
- DONE: done=1 for exactly this cycle; next edge go IDLE unconditionally.
- Output regs sum/cout change only on the final SHIFT edge. They hold their values through IDLE and through the next operation until that operation's final edge.
- start is ignored in SHIFT and DONE; it is not queued. start must be high in IDLE to be accepted.
- a, b, cin are don't-care except on the accepting edge.
- Arithmetic: {cout,sum} == a+b+cin exactly, as a (WIDTH+1)-bit result; no overflow flag.

## Timing
- Reset (reset=0 at an edge): state<=IDLE, busy=0, done=0, sum=0, cout=0, A=B=S=0, C=0, cnt=0.
- Reset mid-operation abandons the operation: no done pulse, outputs forced to 0.
- Reset has priority over a simultaneous start.
- start accepted at edge E0 -> busy=1 from after E0.
- Bit k is processed at edge E0+1+k.
- sum/cout update and done rises after edge E0+WIDTH; done falls and busy falls after edge E0+WIDTH+1.
- Start-to-done latency is WIDTH cycles. Throughput is one operation per WIDTH+2 cycles. The earliest next accept is edge E0+WIDTH+2, i.e. start held high continuously re-triggers every WIDTH+2 cycles.
- busy and done are registered (decoded from state flops), with no combinational path from inputs.

## Test plan
- Reset then start with a=3, b=5, cin=0 (WIDTH=4) -> done exactly 4 edges after accept; sum=8, cout=0; busy high for 5 cycles.
- a=15, b=1, cin=0 -> sum=0, cout=1. Then a=15, b=15, cin=1 -> sum=15, cout=1. The previous sum=0 must be held until the second done.
- Accept a=2, b=2. Pulse start with a=7, b=7 two cycles later while busy -> second request ignored; sum=4, cout=0; only one done pulse.
- Accept a=9, b=6, drive reset=0 on the 2nd SHIFT edge -> busy=0, sum=0, cout=0 next cycle; no done pulse. A following accept of a=1, b=1 yields sum=2.
- Hold start=1 continuously with fixed a=5, b=6, cin=1 -> done pulses every 6 cycles, each with sum=12, cout=0.
- Exhaustive sweep: all a, b in 0..15 and cin in {0,1} -> {cout,sum}==a+b+cin on every done. Repeat the sweep with WIDTH=8 on random vectors.
